mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported, variable-latency memory between the core's instruction-fetch path and its load/store path. It sits between the core and a unified memory. It latches each winning request, drives the memory handshake, returns read data to the owning requester with a one-cycle done pulse, and produces the core stall signal. A per-transaction timeout keeps a dead memory from hanging the core.

---
 rtl/mem_arbiter_if.sv | 78 +++++++
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//
// Bundles every signal between the arbiter, the two core requesters
// (instruction fetch "if_*" and load/store "d_*") and the unified memory
// ("mem_*"). clk and reset are not part of the bundle.
//
// Ports (from the arbiter's point of view, modport slave):
//   in : if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
//        mem_rdata, mem_ready
//   out: if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr,
//        mem_wdata, mem_be, stall, bus_err, dbg_state
// modport master is the mirror image, used by whatever drives the core
// and memory sides (the testbench).
//
// Handshake semantics, in one place:
//   Requester side: a requester raises *_req with stable fields and keeps
//   both unchanged until it sees its *_done pulse (one cycle). The done
//   cycle is the last cycle the request is held; a new request may be
//   presented from the following cycle.
//   Memory side: mem_req plays the role of "valid" and stays high with
//   stable fields until the memory answers with a single-cycle mem_ready
//   ("ready"), or the arbiter gives up after its timeout. mem_rdata is
//   only meaningful in the cycle mem_ready is high.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction fetch requester
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;

    // Load/store requester
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    // Memory port
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    // Core status
    logic          stall;
    logic          bus_err;

    // Arbiter FSM state, exported for observation only
    logic [1:0]    dbg_state;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_rdata, mem_ready,
        output if_rdata, if_done,
        output d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output stall, bus_err, dbg_state
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output mem_rdata, mem_ready,
        input  if_rdata, if_done,
        input  d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  stall, bus_err, dbg_state
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Shares one single-ported, variable-latency memory between the core's
// instruction-fetch path and its load/store path. A winning request is
// latched, presented to memory until mem_ready (or a timeout), and then
// completed with a one-cycle done pulse to its owner, carrying read data.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high
//   bus       mem_arbiter_if.slave, all requester/memory/status signals
// Parameters:
//   AW        address width
//   DW        data width, 32 (byte enables are 4 bits)
//   TIMEOUT   BUSY cycles without mem_ready before abort, 1..255
//
// Flow: IDLE -> BUSY (one grant latched) -> RESP (done pulse) -> IDLE.
// All outputs are registered except stall.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // The counter reads 0 in the first BUSY cycle, so matching TIMEOUT-1
    // means TIMEOUT BUSY cycles have gone by without an answer.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q;
    state_t        state_n;

    // Owner of the current (or most recent) grant. This doubles as the
    // round-robin history: it resets to OWN_D so fetch wins the first tie.
    owner_t        owner_q;

    logic          grant;
    logic          grant_d;
    logic          complete;
    logic          abort;

    logic [7:0]    tmo_q;

    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_done_q;
    logic          d_done_q;
    logic          bus_err_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_n  = state_q;
        grant    = 1'b0;
        grant_d  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    grant   = 1'b1;
                    state_n = ST_BUSY;
                    if (bus.if_req && bus.d_req) begin
                        // Tie: whoever did not win last time goes now.
                        grant_d = (owner_q == OWN_IF);
                    end else begin
                        grant_d = bus.d_req;
                    end
                end
            end

            ST_BUSY: begin
                // A late answer on the final timeout cycle still counts.
                if (bus.mem_ready) begin
                    complete = 1'b1;
                    state_n  = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    abort   = 1'b1;
                    state_n = ST_RESP;
                end
            end

            ST_RESP: begin
                // No grant here: the owner's req is still high this cycle.
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OWN_D;
            tmo_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // Done pulses last exactly the RESP cycle.
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;

            if (grant) begin
                mem_req_q <= 1'b1;
                tmo_q     <= 8'd0;
                if (grant_d) begin
                    owner_q     <= OWN_D;
                    mem_we_q    <= bus.d_we;
                    mem_addr_q  <= bus.d_addr;
                    mem_wdata_q <= bus.d_wdata;
                    mem_be_q    <= bus.d_be;
                end else begin
                    // Fetch is always a full-word read.
                    owner_q     <= OWN_IF;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= bus.if_addr;
                    mem_wdata_q <= '0;
                    mem_be_q    <= 4'hF;
                end
            end

            if (complete || abort) begin
                mem_req_q <= 1'b0;
                if (owner_q == OWN_IF) begin
                    if_done_q <= 1'b1;
                end else begin
                    d_done_q <= 1'b1;
                end
            end else if (state_q == ST_BUSY) begin
                tmo_q <= tmo_q + 8'd1;
            end

            if (complete) begin
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else if (!mem_we_q) begin
                    // A store leaves the load data register alone.
                    d_rdata_q <= bus.mem_rdata;
                end
            end

            if (abort) begin
                bus_err_q <= 1'b1;
                if (owner_q == OWN_IF) begin
                    if_rdata_q <= '0;
                end else begin
                    d_rdata_q <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.dbg_state = state_q;

    // Stall drops in the done cycle so the core can advance on that edge.
    assign bus.stall = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;
    int cyc;
    bit model_ok;
    bit rand_mode;
    bit auto_rearm;
    bit rst_req;
    int dir_lat;
    logic [31:0] dir_rdata;

    // requester state
    bit          if_pend, d_pend, if_rel, d_rel;
    logic [31:0] if_a, d_a, d_wd;
    bit          d_w;
    logic [3:0]  d_b;

    // transaction-level model: one outstanding transaction with its
    // schedule computed at grant time
    bit          tx_act;
    int          tx_s, tx_e, tx_l;
    bit          tx_own;          // 0 = fetch, 1 = data
    bit          tx_we, tx_to;
    logic [31:0] tx_addr, tx_wd, tx_rd;
    logic [3:0]  tx_be;
    bit          last_d;
    logic [31:0] e_if_rd, e_d_rd;
    bit          e_err;
    bit          chk_rst_vals;

    // scoreboard of expected grant addresses
    logic [31:0] exp_q[$];

    // observations of the DUT for the directed literal checks
    int          rise_q[$];
    logic [31:0] rise_addr_q[$];
    logic [3:0]  rise_be_q[$];
    bit          rise_we_q[$];
    int          ifd_q[$];
    int          dd_q[$];
    bit          prev_mem_req;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int qi(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] qa(logic [31:0] q[$], int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_obs();
        rise_q.delete();
        rise_addr_q.delete();
        rise_be_q.delete();
        rise_we_q.delete();
        ifd_q.delete();
        dd_q.delete();
    endtask

    // ---------------- driver + model + compare, one cycle ----------------
    task automatic step();
        bit ready, idle, pick_d;
        bit e_req, e_ifd, e_dd, e_stall;
        @(posedge clk);
        #1;
        cyc++;

        if (if_rel) begin if_rel = 0; if_pend = 0; end
        if (d_rel)  begin d_rel  = 0; d_pend  = 0; end
        if (auto_rearm) begin
            if_pend = 1;
            d_pend  = 1;
        end
        if (rand_mode) begin
            if (!if_pend && $urandom_range(0, 99) < 40) begin
                if_pend = 1;
                if_a    = $urandom;
            end
            if (!d_pend && $urandom_range(0, 99) < 40) begin
                d_pend = 1;
                d_a    = $urandom;
                d_wd   = $urandom;
                d_w    = 1'($urandom_range(0, 1));
                d_b    = 4'($urandom_range(0, 15));
            end
            rst_req = ($urandom_range(0, 399) == 0);
        end

        ready = tx_act && !tx_to && (cyc == tx_s + tx_l - 1);

        reset         = rst_req;
        bus.if_req    = if_pend;
        bus.if_addr   = if_a;
        bus.d_req     = d_pend;
        bus.d_we      = d_w;
        bus.d_addr    = d_a;
        bus.d_wdata   = d_wd;
        bus.d_be      = d_b;
        bus.mem_ready = ready;
        bus.mem_rdata = ready ? tx_rd : $urandom;

        @(negedge clk);

        if (model_ok) begin
            if (tx_act && cyc == tx_e) begin
                if (!tx_own) begin
                    e_if_rd = tx_to ? 32'h0 : tx_rd;
                    if_rel  = 1;
                end else begin
                    if (tx_to)       e_d_rd = 32'h0;
                    else if (!tx_we) e_d_rd = tx_rd;
                    d_rel = 1;
                end
                if (tx_to) e_err = 1;
            end
            e_req   = tx_act && cyc >= tx_s && cyc < tx_e;
            e_ifd   = tx_act && cyc == tx_e && !tx_own;
            e_dd    = tx_act && cyc == tx_e && tx_own;
            e_stall = (if_pend && !e_ifd) || (d_pend && !e_dd);

            chk("mem_req",  32'(bus.mem_req),  32'(e_req));
            chk("if_done",  32'(bus.if_done),  32'(e_ifd));
            chk("d_done",   32'(bus.d_done),   32'(e_dd));
            chk("if_rdata", bus.if_rdata,      e_if_rd);
            chk("d_rdata",  bus.d_rdata,       e_d_rd);
            chk("bus_err",  32'(bus.bus_err),  32'(e_err));
            chk("stall",    32'(bus.stall),    32'(e_stall));
            if (e_req) begin
                chk("mem_addr", bus.mem_addr,      tx_addr);
                chk("mem_we",   32'(bus.mem_we),   32'(tx_we));
                chk("mem_be",   32'(bus.mem_be),   32'(tx_be));
                if (tx_own && tx_we) chk("mem_wdata", bus.mem_wdata, tx_wd);
            end
            if (chk_rst_vals) begin
                chk("rst_mem_addr",  bus.mem_addr,     32'h0);
                chk("rst_mem_wdata", bus.mem_wdata,    32'h0);
                chk("rst_mem_be",    32'(bus.mem_be),  32'h0);
                chk("rst_mem_we",    32'(bus.mem_we),  32'h0);
                chk_rst_vals = 0;
            end
        end

        // observe the DUT
        if (bus.mem_req && !prev_mem_req) begin
            rise_q.push_back(cyc);
            rise_addr_q.push_back(bus.mem_addr);
            rise_be_q.push_back(bus.mem_be);
            rise_we_q.push_back(bus.mem_we);
            if (exp_q.size() == 0) chk("sb_unexpected_grant", bus.mem_addr, 32'hFFFF_FFFF);
            else chk("sb_grant_addr", bus.mem_addr, exp_q.pop_front());
        end
        prev_mem_req = bus.mem_req;
        if (bus.if_done) ifd_q.push_back(cyc);
        if (bus.d_done)  dd_q.push_back(cyc);

        // advance the model
        idle = !tx_act;
        if (tx_act && cyc == tx_e) tx_act = 0;
        if (reset) begin
            tx_act = 0; last_d = 1;
            e_if_rd = 32'h0; e_d_rd = 32'h0; e_err = 0;
            if_pend = 0; d_pend = 0; if_rel = 0; d_rel = 0;
            model_ok = 1; chk_rst_vals = 1;
        end else if (model_ok && idle && (if_pend || d_pend)) begin
            pick_d  = (if_pend && d_pend) ? !last_d : d_pend;
            last_d  = pick_d;
            tx_act  = 1;
            tx_s    = cyc + 1;
            tx_own  = pick_d;
            tx_we   = pick_d ? d_w : 1'b0;
            tx_addr = pick_d ? d_a : if_a;
            tx_wd   = d_wd;
            tx_be   = pick_d ? d_b : 4'hF;
            tx_l    = rand_mode ? int'($urandom_range(1, TMO + 2)) : dir_lat;
            tx_rd   = rand_mode ? $urandom : dir_rdata;
            tx_to   = tx_l > TMO;
            tx_e    = tx_to ? tx_s + TMO : tx_s + tx_l;
            exp_q.push_back(tx_addr);
        end
        rst_req = 0;
    endtask

    task automatic run_idle(int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((if_pend || d_pend || tx_act) && n < budget);
        if (if_pend || d_pend || tx_act) begin
            checks++;
            errors++;
            $display("FAIL run_idle budget expired cyc=%0d got=busy want=idle", cyc);
        end
    endtask

    task automatic do_reset();
        rst_req = 1;
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; errors = 0; cyc = 0; model_ok = 0;
        rand_mode = 0; auto_rearm = 0; rst_req = 0;
        if_pend = 0; d_pend = 0; if_rel = 0; d_rel = 0;
        if_a = 0; d_a = 0; d_wd = 0; d_w = 0; d_b = 0;
        tx_act = 0; last_d = 1; e_if_rd = 0; e_d_rd = 0; e_err = 0;
        chk_rst_vals = 0; prev_mem_req = 0; dir_lat = 1; dir_rdata = 0;
        reset = 1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;

        // reset state
        do_reset();
        step();
        chk("lit_rst_mem_req",  32'(bus.mem_req), 32'h0);
        chk("lit_rst_done",     32'({bus.if_done, bus.d_done}), 32'h0);
        chk("lit_rst_bus_err",  32'(bus.bus_err), 32'h0);
        chk("lit_rst_rdata",    bus.if_rdata | bus.d_rdata, 32'h0);
        chk("lit_rst_stall",    32'(bus.stall), 32'h0);

        // single load, ready two cycles after mem_req rises
        clear_obs();
        d_pend = 1; d_w = 0; d_a = 32'h100; d_b = 4'hF; d_wd = 32'h0;
        dir_lat = 3; dir_rdata = 32'hDEADBEEF;
        run_idle(30);
        chk("lit_load_addr",    qa(rise_addr_q, 0), 32'h100);
        chk("lit_load_be",      32'(qi(rise_q, 0) >= 0 ? rise_be_q[0] : 4'h0), 32'hF);
        chk("lit_load_lat",     32'(qi(dd_q, 0) - qi(rise_q, 0)), 32'd3);
        chk("lit_load_rdata",   bus.d_rdata, 32'hDEADBEEF);

        // store: d_rdata untouched, one done pulse
        clear_obs();
        d_pend = 1; d_w = 1; d_a = 32'h20; d_wd = 32'h12345678; d_b = 4'b0011;
        dir_lat = 2; dir_rdata = 32'hBAD0BAD0;
        run_idle(30);
        chk("lit_store_we",     32'(rise_we_q.size() > 0 ? rise_we_q[0] : 1'b0), 32'h1);
        chk("lit_store_addr",   qa(rise_addr_q, 0), 32'h20);
        chk("lit_store_rdata",  bus.d_rdata, 32'hDEADBEEF);
        chk("lit_store_ndone",  32'(dd_q.size()), 32'd1);

        // contention: both held, immediate ready
        do_reset();
        clear_obs();
        if_a = 32'h1000; d_a = 32'h2000; d_w = 0; d_b = 4'hF;
        dir_lat = 1; dir_rdata = 32'h0;
        auto_rearm = 1;
        repeat (13) step();
        auto_rearm = 0;
        run_idle(30);
        chk("lit_arb_0", qa(rise_addr_q, 0), 32'h1000);
        chk("lit_arb_1", qa(rise_addr_q, 1), 32'h2000);
        chk("lit_arb_2", qa(rise_addr_q, 2), 32'h1000);
        chk("lit_arb_3", qa(rise_addr_q, 3), 32'h2000);
        for (int i = 0; i < 3; i++)
            chk("lit_arb_gap", 32'(qi(rise_q, i + 1) - qi(rise_q, i)), 32'd3);
        chk("lit_arb_ifdone", 32'(qi(ifd_q, 0)), 32'(qi(rise_q, 0) + 1));
        chk("lit_arb_ddone",  32'(qi(dd_q, 0)),  32'(qi(rise_q, 1) + 1));

        // timeout on fetch, memory never answers
        clear_obs();
        if_pend = 1; if_a = 32'h3000; dir_lat = 255; dir_rdata = 32'h0;
        run_idle(40);
        chk("lit_tmo_lat",    32'(qi(ifd_q, 0) - qi(rise_q, 0)), 32'(TMO));
        chk("lit_tmo_rdata",  bus.if_rdata, 32'h0);
        chk("lit_tmo_err",    32'(bus.bus_err), 32'h1);
        d_pend = 1; d_w = 0; d_a = 32'h44; d_b = 4'hF; dir_lat = 2; dir_rdata = 32'h55AA55AA;
        run_idle(30);
        chk("lit_tmo_sticky", 32'(bus.bus_err), 32'h1);
        chk("lit_tmo_after",  bus.d_rdata, 32'h55AA55AA);

        // ready on the timeout cycle itself
        do_reset();
        clear_obs();
        d_pend = 1; d_w = 0; d_a = 32'h40; d_b = 4'hF;
        dir_lat = TMO; dir_rdata = 32'hCAFEF00D;
        run_idle(40);
        chk("lit_edge_err",   32'(bus.bus_err), 32'h0);
        chk("lit_edge_rdata", bus.d_rdata, 32'hCAFEF00D);
        chk("lit_edge_lat",   32'(qi(dd_q, 0) - qi(rise_q, 0)), 32'(TMO));

        // reset in the middle of BUSY
        clear_obs();
        if_pend = 1; if_a = 32'h500; dir_lat = 255;
        repeat (3) step();
        rst_req = 1;
        step();
        step();
        chk("lit_mid_req",    32'(bus.mem_req), 32'h0);
        chk("lit_mid_addr",   bus.mem_addr, 32'h0);
        chk("lit_mid_ndone",  32'(ifd_q.size()), 32'd0);
        if_pend = 1; if_a = 32'h600; dir_lat = 1; dir_rdata = 32'h0BADF00D;
        run_idle(30);
        chk("lit_mid_regrant", 32'(ifd_q.size()), 32'd1);
        chk("lit_mid_rdata",   bus.if_rdata, 32'h0BADF00D);

        // randomized traffic with occasional resets
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        run_idle(100);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
